pipo_load_arbiter: RTL and testbench
====================================

// Module: pipo_load_arbiter
// PURPOSE
//   Shares one WIDTH-bit parallel-in/parallel-out holding register between NREQ requesters.
//   - Round-robin selection of one requester per load.
//   - Loads the winner's word into the register.
//   - Holds the word, tagged with the owner index, until the downstream consumer acknowledges it.
//   - Sits between producer ports and the single shared PIPO datapath register.
// PARAMETERS
//   NREQ   4   number of requesters, >=2
//   WIDTH  4   data width of the shared register
//   IDW    $clog2(NREQ)   owner-index width (derived, not overridden)
// PORTS
//   clk        in   1           clock, rising edge
//   rst        in   1           reset, asynchronous, active-high
//   req_valid  in   NREQ        per-requester word available
//   req_data   in   NREQ*WIDTH  requester i occupies bits [i*WIDTH +: WIDTH]
//   req_ready  out  NREQ        one-hot grant; transfer when req_valid[i] & req_ready[i]
//   out_data   out  WIDTH       shared register contents
//   out_owner  out  IDW         index of requester whose word is in out_data
//   out_valid  out  1           out_data/out_owner hold an unconsumed word
//   out_ack    in   1           consumer takes the word; meaningful only with out_valid=1
// BEHAVIOUR
//   Reset (async assert, sync-safe release):
//   - state=EMPTY; out_valid=0; out_data=0; out_owner=0.
//   - RR pointer last=NREQ-1, so requester 0 has priority first.
//   - req_ready=0 while rst=1.
//   FSM, two states:
//   - EMPTY: out_valid=0.
//   - FULL: out_valid=1.
//   Grant window open = (state==EMPTY) | (state==FULL & out_ack).
//   Arbitration (combinational):
//   - Search req_valid starting at index (last+1) mod NREQ, wrapping.
//   - The first set bit wins.
//   - req_ready = one-hot(winner) if the grant window is open and any req_valid is set; else all zero.
//   - req_ready depends only on state, out_ack, req_valid and last, never on req_data.
//   Load (on the clock edge where a grant is issued):
//   - out_data <= winner word; out_owner <= winner; last <= winner.
//   - state <= FULL.
//   - Latency: word visible on out_data one cycle after acceptance.
//   Transitions:
//   - EMPTY, no valid -> EMPTY.
//   - EMPTY, valid -> FULL (load).
//   - FULL, !out_ack -> FULL. out_data, out_owner and out_valid are held stable.
//   - FULL, out_ack, no valid -> EMPTY. out_data keeps its last value; out_valid=0.
//   - FULL, out_ack, valid -> FULL with the new word (back-to-back, 1 word/cycle throughput).
//   Requester rules:
//   - Once raised, req_valid and its data are held until accepted.
//   - The block never drops an accepted word.
//   - last is updated only on an actual grant, so idle cycles do not rotate priority.
//   Boundaries:
//   - Single requester: gets every grant, i.e. no starvation penalty.
//   - All requesters valid continuously: grants rotate 0,1,2,3,0...
//   - Wrap-around: last=NREQ-1 searches from 0.
//   - out_ack while EMPTY: ignored, no state change.
//   - rst mid-FULL: word discarded, out_valid drops immediately (async).
//     A requester being granted in that cycle is not accepted.
// STRUCTURE
//   Package pipo_ctrl_pkg:
//   - state enum {EMPTY, FULL}.
//   - IDW width function (clog2).
//   Sub-module pipo_reg_en:
//   - WIDTH-bit register with async active-high reset to 0 and a load enable.
//   - Instantiated twice: out_data, and out_owner with width IDW.
//   Arbitration: rotate-and-priority-encode, combinational, inside this module.
// TESTING
//   1. rst=1 mid-run with out_valid=1
//      -> out_valid=0, out_data=0, req_ready=0 same cycle; first later grant goes to req 0.
//   2. Only req_valid[2]=1, data=4'hA; out_ack=0
//      -> req_ready=4'b0100 one cycle; next cycle out_data=A, owner=2, out_valid=1; held 5 cycles.
//   3. All valid (data 1,2,3,4), out_ack=1 constantly
//      -> owners 0,1,2,3,0 on consecutive cycles, out_valid never drops.
//   4. req 1 and req 3 valid, last=3
//      -> req 1 granted, then req 3 after ack; grant order wraps correctly.
//   5. FULL with out_ack=1 and no requests
//      -> next cycle out_valid=0, out_data unchanged; out_ack while EMPTY causes no change.
//   6. Randomised valid/ack with scoreboard
//      -> every accepted (owner,data) appears exactly once, in order, with no loss and no duplicates.

Source files
------------

// File: rtl/pipo_ctrl_pkg.sv
// Shared types for the PIPO load arbiter: register occupancy state and owner-index sizing.
package pipo_ctrl_pkg;

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  function automatic int idw_f(input int n);
    return $clog2(n);
  endfunction

endpackage

// File: rtl/pipo_reg_en.sv
// Plain register with load enable and asynchronous active-high clear to zero.
module pipo_reg_en #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)     q <= '0;
    else if (en) q <= d;
  end

endmodule

// File: rtl/pipo_load_arbiter.sv
// Round-robin arbiter loading one of NREQ producer words into a shared holding register,
// held with its owner index until the consumer acknowledges it.
module pipo_load_arbiter
  import pipo_ctrl_pkg::*;
#(
  parameter  int NREQ  = 4,
  parameter  int WIDTH = 4,
  localparam int IDW   = idw_f(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*WIDTH-1:0] req_data,
  output logic [NREQ-1:0]       req_ready,
  output logic [WIDTH-1:0]      out_data,
  output logic [IDW-1:0]        out_owner,
  output logic                  out_valid,
  input  logic                  out_ack
);

  state_t                       state, state_nx;
  logic [IDW-1:0]               last, winner;
  logic                         any, window, grant;
  logic [NREQ-1:0][WIDTH-1:0]   words;

  assign words = req_data;
  assign any   = |req_valid;

  // Search starts just past the last winner so the previous owner drops to lowest priority.
  always_comb begin
    logic found;
    logic [IDW-1:0] idx;
    winner = '0;
    found  = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      idx = IDW'((int'(last) + 1 + k) % NREQ);
      if (!found && req_valid[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= EMPTY;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      EMPTY:   if (any) state_nx = FULL;
      FULL:    if (out_ack) state_nx = any ? FULL : EMPTY;
      default: state_nx = EMPTY;
    endcase
  end

  // Gating on rst keeps a same-cycle grant from looking accepted to the producer.
  always_comb begin
    out_valid = (state == FULL);
    window    = (state == EMPTY) || out_ack;
    grant     = window && any && !rst;
    req_ready = grant ? (NREQ'(1) << winner) : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)        last <= IDW'(NREQ - 1);
    else if (grant) last <= winner;
  end

  pipo_reg_en #(.W(WIDTH)) u_data (
    .clk (clk),
    .rst (rst),
    .en  (grant),
    .d   (words[winner]),
    .q   (out_data)
  );

  pipo_reg_en #(.W(IDW)) u_owner (
    .clk (clk),
    .rst (rst),
    .en  (grant),
    .d   (winner),
    .q   (out_owner)
  );

endmodule

// File: tb/tb_pipo_load_arbiter.sv
// Directed and scoreboarded random checks for the PIPO load arbiter.
module tb_pipo_load_arbiter;

  localparam int NREQ  = 4;
  localparam int WIDTH = 4;
  localparam int IDW   = 2;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ*WIDTH-1:0] req_data;
  logic [NREQ-1:0]       req_ready;
  logic [WIDTH-1:0]      out_data;
  logic [IDW-1:0]        out_owner;
  logic                  out_valid;
  logic                  out_ack;

  int checks = 0;
  int errors = 0;

  pipo_load_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .out_data  (out_data),
    .out_owner (out_owner),
    .out_valid (out_valid),
    .out_ack   (out_ack)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_word(input int i, input logic [WIDTH-1:0] v);
    req_data[i*WIDTH +: WIDTH] = v;
  endtask

  function automatic logic [NREQ-1:0] rr_pick(input int lst, input logic [NREQ-1:0] v);
    for (int k = 1; k <= NREQ; k++)
      if (v[(lst + k) % NREQ]) return NREQ'(1) << ((lst + k) % NREQ);
    return '0;
  endfunction

  logic [IDW+WIDTH-1:0] sb[$];
  logic [NREQ-1:0]      pend;
  logic [WIDTH-1:0]     pdat[NREQ];
  logic [NREQ-1:0]      exp_rdy;
  logic [IDW+WIDTH-1:0] front;
  int                   mlast;

  initial begin
    rst = 1'b1; req_valid = '0; req_data = '0; out_ack = 1'b0;

    // reset state
    req_valid = 4'b1111;
    #2;
    check("rst_ready", 32'(req_ready), 32'h0);
    check("rst_valid", 32'(out_valid), 32'h0);
    check("rst_data",  32'(out_data),  32'h0);
    check("rst_owner", 32'(out_owner), 32'h0);
    req_valid = '0;
    tick();
    rst = 1'b0;

    // single requester 2, held without ack
    req_valid = 4'b0100; set_word(2, 4'hA);
    #1 check("t2_ready", 32'(req_ready), 32'h4);
    tick();
    req_valid = 4'b0001; set_word(0, 4'h5);
    for (int c = 0; c < 5; c++) begin
      #1;
      check("t2_data",  32'(out_data),  32'hA);
      check("t2_owner", 32'(out_owner), 32'h2);
      check("t2_valid", 32'(out_valid), 32'h1);
      check("t2_noready", 32'(req_ready), 32'h0);
      tick();
    end
    // ack opens window; search from 3 wraps to 0
    out_ack = 1'b1;
    #1 check("t2_next_ready", 32'(req_ready), 32'h1);
    tick();
    req_valid = '0;
    check("t2_b2b_data",  32'(out_data),  32'h5);
    check("t2_b2b_owner", 32'(out_owner), 32'h0);
    check("t2_b2b_valid", 32'(out_valid), 32'h1);

    // ack with no requests empties; ack while empty ignored
    tick();
    check("t5_valid", 32'(out_valid), 32'h0);
    check("t5_data",  32'(out_data),  32'h5);
    for (int c = 0; c < 2; c++) begin
      tick();
      check("t5_idle_valid", 32'(out_valid), 32'h0);
      check("t5_idle_data",  32'(out_data),  32'h5);
    end
    out_ack = 1'b0;

    // drive last to 3, then 1 and 3 valid: 1 wins, 3 next
    req_valid = 4'b1000; set_word(3, 4'h7);
    #1 check("t4_ready3", 32'(req_ready), 32'h8);
    tick();
    req_valid = 4'b1010; set_word(1, 4'h9); set_word(3, 4'hC); out_ack = 1'b1;
    #1 check("t4_ready1", 32'(req_ready), 32'h2);
    tick();
    req_valid = 4'b1000;
    check("t4_data1",  32'(out_data),  32'h9);
    check("t4_owner1", 32'(out_owner), 32'h1);
    #1 check("t4_ready3b", 32'(req_ready), 32'h8);
    tick();
    req_valid = '0;
    check("t4_data3",  32'(out_data),  32'hC);
    check("t4_owner3", 32'(out_owner), 32'h3);
    tick();
    check("t4_empty", 32'(out_valid), 32'h0);

    // all valid, constant ack: rotation 0,1,2,3,0
    req_valid = 4'b1111;
    set_word(0, 4'h1); set_word(1, 4'h2); set_word(2, 4'h3); set_word(3, 4'h4);
    for (int c = 0; c < 5; c++) begin
      #1 check("t3_ready", 32'(req_ready), 32'h1 << (c % 4));
      tick();
      check("t3_owner", 32'(out_owner), 32'(c % 4));
      check("t3_data",  32'(out_data),  32'((c % 4) + 1));
      check("t3_valid", 32'(out_valid), 32'h1);
    end
    req_valid = '0;
    tick();
    out_ack = 1'b0;

    // reset while FULL: immediate drop, priority back to 0
    req_valid = 4'b0010; set_word(1, 4'h6);
    tick();
    req_valid = '0;
    check("t1_pre_valid", 32'(out_valid), 32'h1);
    rst = 1'b1; req_valid = 4'b1111;
    #1;
    check("t1_valid", 32'(out_valid), 32'h0);
    check("t1_data",  32'(out_data),  32'h0);
    check("t1_ready", 32'(req_ready), 32'h0);
    tick();
    rst = 1'b0; req_valid = 4'b0101; set_word(0, 4'hE); set_word(2, 4'h3);
    #1 check("t1_first_ready", 32'(req_ready), 32'h1);
    tick();
    req_valid = 4'b0100;
    check("t1_first_owner", 32'(out_owner), 32'h0);
    check("t1_first_data",  32'(out_data),  32'hE);

    // randomised traffic with scoreboard, from a fresh reset
    rst = 1'b1; req_valid = '0;
    tick();
    rst = 1'b0; mlast = NREQ - 1; pend = '0;
    for (int c = 0; c < 300; c++) begin
      for (int i = 0; i < NREQ; i++)
        if (!pend[i] && ($urandom_range(2) == 0)) begin
          pend[i] = 1'b1; pdat[i] = WIDTH'($urandom);
        end
      for (int i = 0; i < NREQ; i++) set_word(i, pdat[i]);
      req_valid = pend;
      out_ack = 1'($urandom_range(1));
      #1;
      exp_rdy = (!out_valid || out_ack) ? rr_pick(mlast, req_valid) : '0;
      check("rnd_ready", 32'(req_ready), 32'(exp_rdy));
      if (out_valid && out_ack) begin
        if (sb.size() == 0) check("rnd_sb_empty", 32'({out_owner, out_data}), 32'hFFFF);
        else begin
          front = sb.pop_front();
          check("rnd_word", 32'({out_owner, out_data}), 32'(front));
        end
      end
      for (int i = 0; i < NREQ; i++)
        if (exp_rdy[i]) begin
          sb.push_back({IDW'(i), pdat[i]});
          pend[i] = 1'b0; mlast = i;
        end
      tick();
    end
    // drain: last accepted word must be the only one left
    req_valid = '0; out_ack = 1'b1;
    for (int c = 0; c < 4 && sb.size() != 0; c++) begin
      #1;
      if (out_valid) begin
        front = sb.pop_front();
        check("drain_word", 32'({out_owner, out_data}), 32'(front));
      end else check("drain_valid", 32'(out_valid), 32'h1);
      tick();
    end
    check("drain_left", 32'(sb.size()), 32'h0);
    check("drain_empty", 32'(out_valid), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
